// File: rtl/param_shift_add_multiplier.sv
// rtl/param_shift_add_multiplier.sv - WIDTH-bit add-shift multiplier, {X,A,B} product, Busy/Done handshake; define MULT_SIGNED_EN for the two's complement build
//
// Ports:
//   Clk          system clock
//   Reset        asynchronous active-low reset
//   Run          start request (level; a held Run starts only one multiply)
//   ClearA_LoadB clears X/A and loads B from S while idle
//   S            multiplicand / B load value
//   X            sign-extension bit (signed build) or carry bit (unsigned build)
//   Aval         register A, upper half of product
//   Bval         register B, lower half of product
//   Busy         high while a multiplication is in progress
//   Done         one-cycle pulse when the product is valid

module param_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic             X,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHIFT,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic             x_reg, x_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             last_step;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_m;
    logic [WIDTH:0]   sum;
    logic             x_fill;

    // cnt counts completed SHIFTs, so during the last ADD/SHIFT pair it
    // holds WIDTH-1 and B[0] carries the multiplier's top bit.
    assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
    // Two's complement: the multiplier's top bit weighs -2^(WIDTH-1),
    // so the last partial product is subtracted. The shift is arithmetic.
    assign add_a  = {a_reg[WIDTH-1], a_reg};
    assign add_m  = {m_reg[WIDTH-1], m_reg};
    assign sum    = last_step ? (add_a - add_m) : (add_a + add_m);
    assign x_fill = x_reg;
`else
    // Unsigned: X catches the carry-out and is consumed by the next shift.
    assign add_a  = {1'b0, a_reg};
    assign add_m  = {1'b0, m_reg};
    assign sum    = add_a + add_m;
    assign x_fill = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            m_reg    <= '0;
            x_reg    <= 1'b0;
            cnt      <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            a_reg    <= a_next;
            b_reg    <= b_next;
            m_reg    <= m_next;
            x_reg    <= x_next;
            cnt      <= cnt_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        m_next     = m_reg;
        x_next     = x_reg;
        cnt_next   = cnt;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Run) begin
                    // B is deliberately kept so repeated Runs chain-multiply.
                    m_next     = S;
                    a_next     = '0;
                    x_next     = 1'b0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ST_ADD;
                end else if (ClearA_LoadB) begin
                    a_next = '0;
                    x_next = 1'b0;
                    b_next = S;
                end
            end

            ST_ADD: begin
                if (b_reg[0]) begin
                    {x_next, a_next} = sum;
                end
                state_next = ST_SHIFT;
            end

            ST_SHIFT: begin
                {x_next, a_next, b_next} = {x_fill, x_reg, a_reg, b_reg[WIDTH-1:1]};
                cnt_next   = cnt + CW'(1);
                state_next = last_step ? ST_DONE : ST_ADD;
            end

            ST_DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_HOLD;
            end

            ST_HOLD: begin
                // Require Run to drop so a held button cannot retrigger.
                if (!Run) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign X    = x_reg;
    assign Aval = a_reg;
    assign Bval = b_reg;
    assign Busy = busy_reg;
    assign Done = done_reg;

endmodule

// File: tb/tb_param_shift_add_multiplier.sv
// tb/tb_param_shift_add_multiplier.sv - self-checking bench for param_shift_add_multiplier (either MULT_SIGNED_EN build)

module tb_param_shift_add_multiplier;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Run = 1'b0;
    logic         ClearA_LoadB = 1'b0;
    logic [W-1:0] S = '0;
    logic         X;
    logic [W-1:0] Aval;
    logic [W-1:0] Bval;
    logic         Busy;
    logic         Done;

    int           n_pass = 0;
    int           n_total = 0;
    logic [W-1:0] model_b = '0;

    param_shift_add_multiplier #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .X            (X),
        .Aval         (Aval),
        .Bval         (Bval),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #10 Clk = ~Clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: {sign, low 2W bits} of the full product.
    function automatic logic [2*W:0] model(input logic [W-1:0] s, input logic [W-1:0] b);
        longint p;
`ifdef MULT_SIGNED_EN
        p = longint'($signed(s)) * longint'($signed(b));
        return {(p < 0), p[2*W-1:0]};
`else
        p = longint'(s) * longint'(b);
        return {1'b0, p[2*W-1:0]};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic load_b(input logic [W-1:0] v);
        ClearA_LoadB = 1'b1;
        S = v;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        check("load_b", Bval, v);
        check("load_a", Aval, 0);
        check("load_x", X, 0);
        model_b = v;
    endtask

    // Starts a multiply from IDLE. clr_at: sample index at which to pulse
    // ClearA_LoadB with a scrambled S (-1 = never); extra: cycles Run stays
    // high after Done; with_clr: assert ClearA_LoadB together with Run.
    task automatic do_run(input string tag, input logic [W-1:0] s, input int clr_at,
                          input int extra, input bit with_clr);
        logic [2*W:0] e;
        int done_idx;
        int busy_cnt;
        int done_cnt;
        done_idx = -1;
        busy_cnt = 0;
        done_cnt = 0;
        e = model(s, model_b);
        Run = 1'b1;
        S = s;
        ClearA_LoadB = with_clr;
        for (int i = 0; i < 2*W + 2 + extra; i++) begin
            @(negedge Clk);
            if (i == 0) ClearA_LoadB = 1'b0;
            if (i == clr_at) begin
                ClearA_LoadB = 1'b1;
                S = ~s;
            end else if (i == clr_at + 1) begin
                ClearA_LoadB = 1'b0;
            end
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
        end
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        check({tag, "_latency"}, done_idx, 2*W + 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, 2*W + 1);
        check({tag, "_a"}, Aval, e[2*W-1:W]);
        check({tag, "_b"}, Bval, e[W-1:0]);
        check({tag, "_x"}, X, e[2*W]);
        @(negedge Clk);
        check({tag, "_idle_busy"}, Busy, 0);
        check({tag, "_idle_done"}, Done, 0);
        model_b = e[W-1:0];
    endtask

    initial begin
        int done_seen;
        #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_x", X, 0);
        check("rst_a", Aval, 0);
        check("rst_b", Bval, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset = 1'b1;
        @(negedge Clk);

        // Directed products
        load_b(8'h07);
        do_run("p59x7", 8'h3B, -1, 0, 0);
        load_b(8'hF9);
        do_run("p59xf9", 8'h3B, -1, 0, 0);
        load_b(8'hFF);
        do_run("pffxff", 8'hFF, -1, 0, 0);
        load_b(8'h80);
        do_run("p80x80", 8'h80, -1, 0, 0);
        load_b(8'h00);
        do_run("p0xff", 8'hFF, -1, 0, 0);

        // Run held for 40 cycles, then chained run by 2
        load_b(8'h07);
        do_run("hold40", 8'h3B, -1, 40 - (2*W + 2), 0);
        do_run("chain2", 8'h02, -1, 0, 0);

        // ClearA_LoadB / S changes mid-operation are ignored
        load_b(8'($urandom));
        do_run("midclr", 8'($urandom), 5, 0, 0);

        // Run and ClearA_LoadB together: Run wins, B not reloaded
        load_b(8'($urandom));
        do_run("runclr", 8'($urandom), -1, 0, 1);

        // Random operands, each followed by a chained multiply
        for (int k = 0; k < 6; k++) begin
            load_b(8'($urandom));
            do_run("rnd", 8'($urandom), -1, 0, 0);
            do_run("rnd_chain", 8'($urandom), -1, 0, 0);
        end

        // Reset mid-operation
        load_b(8'hA5);
        Run = 1'b1;
        S = 8'h5A;
        repeat (5) @(negedge Clk);
        #3 Reset = 1'b0;
        #1;
        check("mid_rst_x", X, 0);
        check("mid_rst_a", Aval, 0);
        check("mid_rst_b", Bval, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_done", Done, 0);
        Run = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Done || Busy) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        model_b = '0;
        load_b(8'h07);
        do_run("post_rst", 8'h3B, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
